led_pwm: RTL

Parametrised memory-mapped LED controller on the single-cycle strobe bus. It drives NUM_LEDS outputs, each with an enable bit, an 8-bit-class PWM duty, and an optional blink gate. Duty changes are double-buffered to the PWM period boundary, so they never cause output glitches. The block replaces the fixed 8-bit LED latch in the peripheral address space and adds a registered acknowledge and readback.

---
 rtl/led_pwm_if.sv | 20 ++
 rtl/led_pwm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/led_pwm_if.sv
// Single-cycle strobe bus between a master and the LED controller.
// The master holds i_stb until it sees o_ack; o_dat_r is valid only while o_ack=1.
interface led_pwm_if;
  logic        i_stb;
  logic        i_we;
  logic [5:0]  i_adr;
  logic [31:0] i_dat_w;
  logic [31:0] o_dat_r;
  logic        o_ack;

  modport master (
    output i_stb, i_we, i_adr, i_dat_w,
    input  o_dat_r, o_ack
  );

  modport slave (
    input  i_stb, i_we, i_adr, i_dat_w,
    output o_dat_r, o_ack
  );
endinterface

// File: rtl/led_pwm.sv
// Memory-mapped LED controller: per-channel enable, PWM duty and blink gate.
// Duty writes land in a shadow register and are copied to the active duty only
// at the PWM period boundary, so a running period is never cut short.
module led_pwm #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int CLK_DIV  = 99
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  led_pwm_if.slave            bus,
  output logic [NUM_LEDS-1:0] o_led
);

  localparam int                DIV_W      = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_TC     = DIV_W'(CLK_DIV);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
  localparam logic [5:0]        ADR_ENABLE = 6'd0;
  localparam logic [5:0]        ADR_BLINK  = 6'd1;
  localparam logic [5:0]        ADR_PERIOD = 6'd2;
  localparam logic [5:0]        ADR_STATUS = 6'd3;
  localparam logic [5:0]        ADR_DUTY0  = 6'd4;
  localparam logic [6:0]        DUTY_END   = 7'(4 + NUM_LEDS);

  // Register file
  logic [NUM_LEDS-1:0] enable_q;
  logic [NUM_LEDS-1:0] blink_q;
  logic [15:0]         period_q;
  logic [PWM_BITS-1:0] duty_q   [NUM_LEDS];
  logic [PWM_BITS-1:0] active_q [NUM_LEDS];

  // Timebase
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [15:0]         blink_cnt;
  logic                phase;
  logic                tick;
  logic                wrap;
  logic [15:0]         period_eff;

  // Bus
  logic                ack_q;
  logic [31:0]         dat_r_q;
  logic [31:0]         rd_data;
  logic                accept;
  logic                wr_en;
  logic                duty_hit;
  logic [5:0]          duty_idx;
  logic [NUM_LEDS-1:0] pwm_on;
  logic                unused_bits;

  assign accept      = bus.i_stb & ~ack_q;
  assign wr_en       = accept & bus.i_we;
  assign duty_idx    = bus.i_adr - ADR_DUTY0;
  assign duty_hit    = (bus.i_adr >= ADR_DUTY0) && ({1'b0, bus.i_adr} < DUTY_END);
  assign tick        = (div_cnt == DIV_TC);
  assign wrap        = tick && (pwm_cnt == PWM_MAX);
  assign period_eff  = (period_q == 16'd0) ? 16'd1 : period_q;
  assign bus.o_ack   = ack_q;
  assign bus.o_dat_r = dat_r_q;
  assign unused_bits = ^bus.i_dat_w;

  // Read mux: unmapped addresses and unused bits read as zero
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned, which would infer a latch.
    rd_data = '0;
    case (bus.i_adr)
      ADR_ENABLE: rd_data[NUM_LEDS-1:0] = enable_q;
      ADR_BLINK:  rd_data[NUM_LEDS-1:0] = blink_q;
      ADR_PERIOD: rd_data[15:0]         = period_q;
      ADR_STATUS: begin
        rd_data[PWM_BITS-1:0] = pwm_cnt;
        rd_data[16]           = phase;
      end
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (duty_hit && (duty_idx == 6'(i))) rd_data[PWM_BITS-1:0] = duty_q[i];
        end
      end
    endcase
  end

  // Acknowledge one clock after accept; read data only alongside the ack
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!i_rst_n) begin
      ack_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      ack_q   <= accept;
      dat_r_q <= (accept && !bus.i_we) ? rd_data : '0;
    end
  end

  // Writable registers, updated on the accept edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      enable_q <= '0;
      blink_q  <= '0;
      period_q <= 16'h0001;
      // NOTE: the duty array has a defined reset value, so it is reset element by element (flops, not RAM).
      for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '1;
    end else if (wr_en) begin
      case (bus.i_adr)
        ADR_ENABLE: enable_q <= bus.i_dat_w[NUM_LEDS-1:0];
        ADR_BLINK:  blink_q  <= bus.i_dat_w[NUM_LEDS-1:0];
        ADR_PERIOD: period_q <= bus.i_dat_w[15:0];
        default: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (duty_hit && (duty_idx == 6'(i))) duty_q[i] <= bus.i_dat_w[PWM_BITS-1:0];
          end
        end
      endcase
    end
  end

  // Copy shadow duties to the active set at the period boundary
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) active_q[i] <= '1;
    end else if (wrap) begin
      for (int i = 0; i < NUM_LEDS; i++) active_q[i] <= duty_q[i];
    end
  end

  // Prescaler and PWM counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Blink phase toggles every period_eff PWM periods; a shrunk period applies at the next wrap
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (wrap) begin
      if (({1'b0, blink_cnt} + 17'd1) >= {1'b0, period_eff}) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // Per-channel PWM compare; full-scale duty means always on
  always_comb begin
    pwm_on = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      pwm_on[i] = (active_q[i] == PWM_MAX) || (pwm_cnt < active_q[i]);
    end
  end

  // Registered LED outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_led <= '0;
    else          o_led <= enable_q & pwm_on & (~blink_q | {NUM_LEDS{phase}});
  end

endmodule
